// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and baud divider helper
//
// Contents:
//   IDLE/START/DATA/STOP/BREAK : 3-bit receiver state codes
//   OS_DEFAULT                 : default samples per bit
//   DATA_BITS                  : payload bits per frame
//   baud_div()                 : clock cycles per oversample tick, integer-truncated
package uart_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  localparam int OS_DEFAULT = 16;
  localparam int DATA_BITS  = 8;

  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running oversample tick generator with synchronous clear
//
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   i_clr   : synchronous clear; restarts the count so the next tick lands DIV clocks later
//   o_tick  : one-clock pulse when the counter wraps from DIV-1 to 0
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);
  // A clear in the same cycle as a wrap wins, so the caller never sees a stale tick.
  assign o_tick = w_wrap && !i_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 8N1 UART receiver, 16x oversampling with mid-bit majority vote
//
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   rxd       : serial input, asynchronous, idle high
//   rx_data   : last correctly framed byte, held until the next good frame
//   rx_valid  : one-clock pulse, rx_data updated this cycle
//   frame_err : one-clock pulse, stop bit sampled low
//   busy      : high from start detect until the frame ends
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = OS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SAMP_C    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  logic                 r_rxd_meta;
  logic                 r_rxd_s;
  logic [SW-1:0]        r_samp;
  logic                 r_smp_a;
  logic                 r_smp_b;
  logic                 r_vote;
  logic                 r_vote_done;
  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;

  logic                 w_tick;
  logic                 w_clr;
  logic                 w_bit_end;
  logic                 w_busy;
  logic                 w_load;
  logic                 w_ferr;
  logic                 w_shift;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_meta <= 1'b1;
      r_rxd_s    <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_s    <= r_rxd_meta;
    end
  end

  assign w_bit_end = w_tick && (r_samp == SAMP_LAST);

  // Sample counter gives the position within the current bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samp <= '0;
    end else if (w_clr) begin
      r_samp <= '0;
    end else if (w_tick) begin
      r_samp <= (r_samp == SAMP_LAST) ? '0 : r_samp + SW'(1);
    end
  end

  // Three mid-bit samples; the decision is registered on the third tick and
  // r_vote_done marks the following cycle, when the FSM consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp_a     <= 1'b1;
      r_smp_b     <= 1'b1;
      r_vote      <= 1'b1;
      r_vote_done <= 1'b0;
    end else begin
      r_vote_done <= 1'b0;
      if (w_tick && r_samp == SAMP_A) r_smp_a <= r_rxd_s;
      if (w_tick && r_samp == SAMP_B) r_smp_b <= r_rxd_s;
      if (w_tick && r_samp == SAMP_C) begin
        r_vote      <= (r_smp_a & r_smp_b) | (r_smp_a & r_rxd_s) | (r_smp_b & r_rxd_s);
        r_vote_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (!r_rxd_s) w_next = START;
      START: begin
        if (r_vote_done && r_vote) w_next = IDLE;
        else if (w_bit_end)        w_next = DATA;
      end
      DATA:  if (w_bit_end && r_bit_idx == IDX_LAST) w_next = STOP;
      // Leaving at mid-stop leaves half a bit to catch the next start edge.
      STOP:  if (r_vote_done) w_next = r_vote ? IDLE : BREAK;
      // Ticks only survive while the line stays high, so one tick means a
      // full tick period of idle line.
      BREAK: if (w_tick) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state != IDLE);
    w_load  = (r_state == STOP) && r_vote_done && r_vote;
    w_ferr  = (r_state == STOP) && r_vote_done && !r_vote;
    w_shift = (r_state == DATA) && r_vote_done;
    w_clr   = ((r_state == IDLE) && !r_rxd_s) ||
              ((r_state == BREAK) && !r_rxd_s) ||
              w_ferr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= w_load;
      r_frame_err <= w_ferr;
      if (w_shift) r_shift <= {r_vote, r_shift[DATA_BITS-1:1]};
      if (w_load)  r_rx_data <= r_shift;
      if (r_state == START && w_bit_end)     r_bit_idx <= '0;
      else if (r_state == DATA && w_bit_end) r_bit_idx <= r_bit_idx + BW'(1);
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = w_busy;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - self-checking bench for uart_rx_oversample
module tb_uart_rx_oversample;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int n_vec = 0;
  int n_mis = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         fe_cnt = 0;
  int         excl_bad = 0;
  bit         prev_pulse = 1'b0;
  realtime    t_fall = 0;
  realtime    t_valid = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx_oversample dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #10ns clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        got_q.push_back(rx_data);
        t_valid = $realtime;
      end
      if (frame_err) fe_cnt++;
      if (rx_valid && frame_err) excl_bad++;
      if ((rx_valid || frame_err) && prev_pulse) excl_bad++;
      prev_pulse = rx_valid || frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bits(input real bit_ns, input real nbits);
    rxd = 1'b1;
    #(bit_ns * nbits * 1ns);
  endtask

  // Start bit, 8 data bits LSB first, one stop bit; a low stop bit leaves the line low.
  task automatic send_frame(input logic [7:0] b, input real bit_ns, input logic stop_bit);
    t_fall = $realtime;
    rxd = 1'b0;
    #(bit_ns * 1ns);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(bit_ns * 1ns);
    end
    rxd = stop_bit;
    #(bit_ns * 1ns);
    if (stop_bit) rxd = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b, input real bit_ns);
    exp_q.push_back(b);
    last_good = b;
    send_frame(b, bit_ns, 1'b1);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_byte"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int   fe0;
    real  lat;
    real  per;
    logic [7:0] b;

    rxd   = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1ns;
    chk("reset_rx_data", {24'h0, rx_data}, 32'h0);
    chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    idle_bits(8680.0, 2.0);

    // 1: single nominal frame with latency window around 9.6 bit periods
    fe0 = fe_cnt;
    send_good(8'hA5, 8680.0);
    idle_bits(8680.0, 1.0);
    lat = (t_valid - t_fall) / (8680.0 * 1ns);
    chk("t1_latency_window", {31'h0, (lat >= 9.3 && lat <= 9.9)}, 32'h1);
    chk("t1_busy_idle", {31'h0, busy}, 32'h0);
    chk("t1_no_ferr", fe_cnt - fe0, 0);
    drain("t1");

    // 2: short glitch is rejected
    fe0 = fe_cnt;
    rxd = 1'b0;
    #1000ns;
    chk("t2_busy_in_glitch", {31'h0, busy}, 32'h1);
    #1000ns;
    rxd = 1'b1;
    #(8680ns - 2000ns);
    chk("t2_busy_recovered", {31'h0, busy}, 32'h0);
    idle_bits(8680.0, 1.0);
    chk("t2_no_ferr", fe_cnt - fe0, 0);
    drain("t2");

    // 3: bad stop bit then held-low break
    fe0 = fe_cnt;
    send_frame(8'h3C, 8680.0, 1'b0);
    #(5 * 8680ns);
    idle_bits(8680.0, 2.0);
    chk("t3_single_ferr", fe_cnt - fe0, 1);
    chk("t3_rx_data_held", {24'h0, rx_data}, {24'h0, last_good});
    chk("t3_busy_idle", {31'h0, busy}, 32'h0);
    drain("t3");

    // 4: back-to-back frames, one stop bit each
    send_good(8'h00, 8680.0);
    send_good(8'hFF, 8680.0);
    send_good(8'h5A, 8680.0);
    idle_bits(8680.0, 2.0);
    drain("t4");

    // 5: reset during data bit 4 of 8'h81
    rxd = 1'b0;
    #8680ns;
    for (int i = 0; i < 4; i++) begin
      rxd = 8'h81 >> i;
      #8680ns;
    end
    rxd = 1'b0;
    #4000ns;
    rst_n = 1'b0;
    #100ns;
    chk("t5_rst_rx_data", {24'h0, rx_data}, 32'h0);
    chk("t5_rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("t5_rst_busy", {31'h0, busy}, 32'h0);
    #4580ns;
    for (int i = 5; i < 8; i++) begin
      rxd = 8'h81 >> i;
      #8680ns;
    end
    idle_bits(8680.0, 3.0);
    rst_n = 1'b1;
    idle_bits(8680.0, 2.0);
    fe0 = fe_cnt;
    send_good(8'h7E, 8680.0);
    idle_bits(8680.0, 2.0);
    chk("t5_no_ferr", fe_cnt - fe0, 0);
    drain("t5");

    // 6: +/-2% line rate
    fe0 = fe_cnt;
    send_good(8'hA5, 8507.0);
    send_good(8'h55, 8507.0);
    send_good(8'hAA, 8507.0);
    idle_bits(8680.0, 1.0);
    send_good(8'hA5, 8854.0);
    send_good(8'h55, 8854.0);
    send_good(8'hAA, 8854.0);
    idle_bits(8680.0, 2.0);
    chk("t6_no_ferr", fe_cnt - fe0, 0);
    drain("t6");

    // Randomised frames, rates and idle gaps
    fe0 = fe_cnt;
    for (int n = 0; n < 16; n++) begin
      b   = 8'($urandom);
      per = 8507.0 + real'($urandom_range(0, 347));
      send_good(b, per);
      idle_bits(per, real'($urandom_range(0, 2)));
    end
    idle_bits(8680.0, 2.0);
    chk("rnd_no_ferr", fe_cnt - fe0, 0);
    chk("rnd_last_data", {24'h0, rx_data}, {24'h0, last_good});
    drain("rnd");

    chk("pulse_exclusive", excl_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
